// File: rtl/audiodac_pkg.sv
`default_nettype none
// ============================================================================
// Module : audiodac_pkg
// Brief  : Shared constants for the audio DAC datapath (FIFO, modulator, bus).
// Rev    : 1.0  initial release
// ============================================================================
package audiodac_pkg;

    localparam int DEFAULT_BW         = 16;
    localparam int DEFAULT_DEPTH_LOG2 = 5;
    localparam logic [DEFAULT_BW-1:0] DATA_MID = {1'b1, {(DEFAULT_BW-1){1'b0}}};

endpackage : audiodac_pkg
`default_nettype wire

// File: rtl/audiodac_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : audiodac_fifo_if
// Brief  : Host/modulator side bundle of the audio sample FIFO.
// Rev    : 1.0  initial release
// ============================================================================
interface audiodac_fifo_if
    import audiodac_pkg::*;
#(
    parameter int BW         = DEFAULT_BW,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);
    logic [BW-1:0]         wr_data_i;
    logic                  wr_en_i;
    logic                  rd_i;
    logic [BW-1:0]         data_o;
    logic                  full_o;
    logic                  empty_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic [DEPTH_LOG2-1:0] thresh_i;
    logic                  irq_o;
    logic                  clr_i;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output wr_data_i, wr_en_i, rd_i, thresh_i, clr_i,
        input  data_o, full_o, empty_o, level_o, irq_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_data_i, wr_en_i, rd_i, thresh_i, clr_i,
        output data_o, full_o, empty_o, level_o, irq_o, overflow_o, underflow_o
    );
endinterface : audiodac_fifo_if
`default_nettype wire

// File: rtl/audiodac_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : audiodac_fifo_mem
// Brief  : Simple dual-port register array, one write port, registered read.
// Rev    : 1.0  initial release
// ============================================================================
module audiodac_fifo_mem #(
    parameter int BW = 16,
    parameter int AW = 5
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [BW-1:0] wdata,
    input  wire logic          re,
    input  wire logic [AW-1:0] raddr,
    output logic      [BW-1:0] rdata
);
    logic [BW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule : audiodac_fifo_mem
`default_nettype wire

// File: rtl/audiodac_fifo.sv
`default_nettype none
// ============================================================================
// Module : audiodac_fifo
// Brief  : Sample FIFO feeding the delta-sigma modulator; holds last sample on
//          underrun, with level/irq status and sticky over/underflow flags.
// Rev    : 1.0  initial release
// ============================================================================
module audiodac_fifo
    import audiodac_pkg::*;
#(
    parameter int BW         = DEFAULT_BW,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    audiodac_fifo_if.slave bus
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = DEPTH[DEPTH_LOG2:0];
    localparam logic [BW-1:0]       MID      = {1'b1, {(BW-1){1'b0}}};

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] level;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                overflow;
    logic                underflow;
    logic                mem_valid;
    logic [BW-1:0]       mem_q;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign push  = bus.wr_en_i && !full;
    assign pop   = bus.rd_i && !empty;

    audiodac_fifo_mem #(
        .BW (BW),
        .AW (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk_i),
        .we    (push),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (bus.wr_data_i),
        .re    (pop),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (mem_q)
    );

    // The array has no reset, so mem_valid masks its stale read register with
    // midscale until the first real pop after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                mem_valid <= 1'b1;
            end
            overflow  <= (overflow  && !bus.clr_i) || (bus.wr_en_i && full);
            underflow <= (underflow && !bus.clr_i) || (bus.rd_i && empty);
        end
    end

    assign bus.data_o      = mem_valid ? mem_q : MID;
    assign bus.level_o     = level;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.irq_o       = (level <= {1'b0, bus.thresh_i});
    assign bus.overflow_o  = overflow;
    assign bus.underflow_o = underflow;
endmodule : audiodac_fifo
`default_nettype wire

// File: tb/tb_audiodac_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_audiodac_fifo
// Brief  : Directed self-checking bench for audiodac_fifo.
// Rev    : 1.0  initial release
// ============================================================================
module tb_audiodac_fifo;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    audiodac_fifo_if #(.BW(16), .DEPTH_LOG2(5)) bus ();

    audiodac_fifo #(.BW(16), .DEPTH_LOG2(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = d;
        tick();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic pop();
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] nxt;
        logic [15:0] exp;

        rst_n         = 1'b0;
        bus.wr_data_i = '0;
        bus.wr_en_i   = 1'b0;
        bus.rd_i      = 1'b0;
        bus.clr_i     = 1'b0;
        bus.thresh_i  = 5'd8;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_data",  bus.data_o,      16'h8000);
        chk("rst_empty", bus.empty_o,     1'b1);
        chk("rst_full",  bus.full_o,      1'b0);
        chk("rst_level", bus.level_o,     6'd0);
        chk("rst_irq",   bus.irq_o,       1'b1);
        chk("rst_ovf",   bus.overflow_o,  1'b0);
        chk("rst_unf",   bus.underflow_o, 1'b0);

        // Basic push / pop order
        push(16'h1234);
        chk("push1_level", bus.level_o, 6'd1);
        chk("push1_empty", bus.empty_o, 1'b0);
        chk("push1_data",  bus.data_o,  16'h8000);
        push(16'hABCD);
        chk("push2_level", bus.level_o, 6'd2);
        pop();
        chk("pop1_data",  bus.data_o,  16'h1234);
        chk("pop1_level", bus.level_o, 6'd1);
        pop();
        chk("pop2_data",  bus.data_o,  16'hABCD);
        chk("pop2_empty", bus.empty_o, 1'b1);

        // Underflow holds last sample; clear and clear-vs-new-event
        pop();
        chk("unf_data",  bus.data_o,      16'hABCD);
        chk("unf_flag",  bus.underflow_o, 1'b1);
        chk("unf_level", bus.level_o,     6'd0);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        chk("unf_clr", bus.underflow_o, 1'b0);
        bus.clr_i = 1'b1;
        bus.rd_i  = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        bus.rd_i  = 1'b0;
        chk("unf_clr_collide", bus.underflow_o, 1'b1);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        chk("unf_clr2", bus.underflow_o, 1'b0);

        // Fill to 32, overflow with 0x5555, drain and verify order
        for (int i = 0; i < 32; i++) begin
            push(16'h0100 + 16'(i));
            if (i == 7)  chk("irq_at_thresh", bus.irq_o, 1'b1);
            if (i == 8)  chk("irq_above",     bus.irq_o, 1'b0);
            if (i == 30) chk("full_at_31",    bus.full_o, 1'b0);
        end
        chk("fill_full",  bus.full_o,  1'b1);
        chk("fill_level", bus.level_o, 6'd32);
        chk("fill_ovf0",  bus.overflow_o, 1'b0);
        push(16'h5555);
        chk("ovf_flag",  bus.overflow_o, 1'b1);
        chk("ovf_level", bus.level_o,    6'd32);
        // Pop while full does not make room for a same-cycle push
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 16'h5555;
        bus.rd_i      = 1'b1;
        tick();
        bus.wr_en_i   = 1'b0;
        bus.rd_i      = 1'b0;
        chk("full_pp_data",  bus.data_o,  16'h0100);
        chk("full_pp_level", bus.level_o, 6'd31);
        for (int i = 1; i < 32; i++) begin
            pop();
            chk("drain_data", bus.data_o, 16'h0100 + 16'(i));
        end
        chk("drain_empty", bus.empty_o, 1'b1);
        chk("drain_ovf",   bus.overflow_o, 1'b1);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        chk("ovf_clr", bus.overflow_o, 1'b0);

        // Push + pop while empty: pop underflows, push lands
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 16'h7777;
        bus.rd_i      = 1'b1;
        tick();
        bus.wr_en_i   = 1'b0;
        bus.rd_i      = 1'b0;
        chk("empty_pp_level", bus.level_o,     6'd1);
        chk("empty_pp_unf",   bus.underflow_o, 1'b1);
        chk("empty_pp_data",  bus.data_o,      16'h011F);
        pop();
        chk("empty_pp_pop", bus.data_o, 16'h7777);

        // Streaming at level 16 across 100 pointer wraps
        nxt = 16'h2000;
        for (int i = 0; i < 16; i++) begin
            q.push_back(nxt);
            push(nxt);
            nxt++;
        end
        chk("stream_level0", bus.level_o, 6'd16);
        for (int i = 0; i < 6400; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = nxt;
            bus.rd_i      = 1'b1;
            tick();
            exp = q.pop_front();
            q.push_back(nxt);
            nxt++;
            chk("stream_data", bus.data_o, exp);
            if (bus.level_o !== 6'd16) chk("stream_level", bus.level_o, 6'd16);
        end
        bus.wr_en_i = 1'b0;
        bus.rd_i    = 1'b0;
        chk("stream_level_end", bus.level_o, 6'd16);

        // Drain to 10, then async reset mid-burst
        for (int i = 0; i < 6; i++) begin
            pop();
            exp = q.pop_front();
            chk("pre_rst_data", bus.data_o, exp);
        end
        chk("pre_rst_level", bus.level_o, 6'd10);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 16'h4321;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", bus.level_o, 6'd0);
        chk("arst_data",  bus.data_o,  16'h8000);
        chk("arst_empty", bus.empty_o, 1'b1);
        chk("arst_irq",   bus.irq_o,   1'b1);
        bus.wr_en_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_level", bus.level_o, 6'd0);
        chk("post_rst_data",  bus.data_o,  16'h8000);
        pop();
        chk("post_rst_pop_data", bus.data_o,      16'h8000);
        chk("post_rst_unf",      bus.underflow_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_audiodac_fifo
`default_nettype wire

// File: doc/audiodac_fifo.md
# audiodac_fifo

Sample buffer directly upstream of the audio delta-sigma modulator. A host or bus interface pushes UINT audio samples in bursts at any rate. The modulator pops exactly one sample per oversampling period with its single-cycle read strobe. The block provides full/empty/level status, a refill interrupt, and sticky overflow and underflow flags. On underrun it holds the last sample, so the DAC output does not click.

## Interface
- `BW`, 16, sample width (UINT, midscale = 1 followed by BW-1 zeros)
- `DEPTH_LOG2`, 5, log2 of FIFO depth (default 32 entries)
- `clk_i`  in  1  clock, same clock as the modulator
- `rst_n_i`  in  1  reset; one clock; reset is asynchronous and active-low
- `wr_data_i`  in  BW  sample to push
- `wr_en_i`  in  1  push strobe, one sample per high cycle
- `rd_i`  in  1  pop strobe, driven by the modulator's fetch output
- `data_o`  out  BW  current sample to the modulator (registered)
- `full_o`  out  1  FIFO holds DEPTH entries
- `empty_o`  out  1  FIFO holds 0 entries
- `level_o`  out  DEPTH_LOG2+1  number of stored entries
- `thresh_i`  in  DEPTH_LOG2  refill threshold
- `irq_o`  out  1  refill request, high while level_o <= thresh_i
- `clr_i`  in  1  clears sticky flags
- `overflow_o`  out  1  sticky: push attempted while full
- `underflow_o`  out  1  sticky: pop attempted while empty

## Operation
- Storage is DEPTH x BW. Storage is not reset.
- Write pointer and read pointer are each DEPTH_LOG2+1 bits and wrap naturally modulo 2*DEPTH.
- level_o = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
- empty_o = (level_o == 0); full_o = (level_o == DEPTH).
- Push: wr_en_i high and full_o low. Store wr_data_i at wr_ptr, then wr_ptr+1.
- Push while full_o is high: the sample is dropped, pointers are unchanged, and overflow_o is set.
- full_o is the value before the edge. A simultaneous pop does not rescue a push into a full FIFO.
- Pop: rd_i high and empty_o low. data_o <= mem[rd_ptr], then rd_ptr+1.
- Pop while empty_o is high: data_o holds its value, pointers are unchanged, and underflow_o is set.
- Push and pop in the same cycle, not full and not empty: both are performed and level is unchanged.
- Push and pop in the same cycle while empty: the pop underflows (no write-through bypass) and the push is accepted, so level becomes 1.
- clr_i clears overflow_o and underflow_o. If a new overflow or underflow event occurs in the same cycle as clr_i, the flag stays set.
- irq_o = (level_o <= thresh_i), combinational from registered state. thresh_i is sampled continuously.

## Timing
- Reset (asynchronous assert, release synchronised by the system):
  - pointers = 0, so level_o = 0, empty_o = 1, full_o = 0
  - data_o = midscale (0x8000 for BW=16)
  - overflow_o = underflow_o = 0
  - irq_o = 1
- A reset asserted mid-operation discards all stored samples immediately and returns data_o to midscale.
- Push latency: a push at edge N updates level_o, empty_o, full_o and irq_o after edge N. A pop at edge N+1 returns that sample.
- Pop latency: data_o changes at the same edge that samples rd_i high. The modulator sees the new sample from the next cycle on.
- Sticky flags become visible the cycle after the offending edge.
- No combinational path from any input to data_o.

## Structure
- Shared header/package `audiodac_pkg`:
  - default BW
  - DATA_MID midscale constant
  - default DEPTH_LOG2
- These constants are shared with the modulator and the bus interface.
- Sub-module `audiodac_fifo_mem`: simple dual-port register array with one write port and one registered read port, no reset.
- Pointer, flag and status logic lives in `audiodac_fifo`.

## Test plan
- Reset, then no stimulus: data_o=0x8000, empty_o=1, level_o=0, irq_o=1 with thresh_i=8.
- Push 0x1234, 0xABCD; pop twice: data_o=0x1234, then 0xABCD; empty_o=1 after the second pop.
- Push 32 samples, then push 0x5555: full_o=1, level_o=32, overflow_o=1; pop all 32 and check that 0x5555 never appears.
- Pop while empty after last sample 0xABCD: data_o stays 0xABCD, underflow_o=1; clr_i clears it; clr_i together with another empty pop keeps underflow_o=1.
- Run 100 pointer wraps with simultaneous push/pop at level 16: level_o stays 16 and output order matches input order.
- Assert rst_n_i low mid-burst at level 10: level_o=0 and data_o=0x8000 immediately, with no clock edge required.
